// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Owns one sprite's position and heading inside a bounded playfield. Button
//   presses are latched as a pending turn that is taken on the first movement
//   tick where the maze does not block it. At the edges the sprite either wraps
//   or clamps. A frame-synchronous pixel test produces the hit flag and the
//   sprite-local ROM address one clock after the pixel counters.
// Ports
//   clk, rst            pixel clock, synchronous active-low reset
//   tick                one-cycle movement strobe
//   bright              display-area flag
//   up/down/left/right  button levels
//   blocked[3:0]        wall ahead per direction {down,up,left,right}
//   hCount, vCount      raster position
//   xpos, ypos          live sprite top-left
//   dir                 heading 0=R 1=L 2=U 3=D
//   moving              sprite is in the MOVING state
//   sprite_hit          previous-cycle pixel lies inside the sprite
//   spr_row, spr_col    sprite-local ROM address (0 when no hit)
//   background          colour of the last accepted direction
module sprite_motion_ctrl #(
    parameter int SPR_W  = 30,
    parameter int SPR_H  = 30,
    parameter int STEP   = 2,
    parameter int X_MIN  = 144,
    parameter int X_MAX  = 753,
    parameter int Y_MIN  = 35,
    parameter int Y_MAX  = 485,
    parameter int X_INIT = 450,
    parameter int Y_INIT = 250,
    parameter bit WRAP   = 1'b1,
    parameter bit MIRROR = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       bright,
    input  logic                       up,
    input  logic                       down,
    input  logic                       left,
    input  logic                       right,
    input  logic [3:0]                 blocked,
    input  logic [9:0]                 hCount,
    input  logic [9:0]                 vCount,
    output logic [9:0]                 xpos,
    output logic [9:0]                 ypos,
    output logic [1:0]                 dir,
    output logic                       moving,
    output logic                       sprite_hit,
    output logic [$clog2(SPR_H)-1:0]   spr_row,
    output logic [$clog2(SPR_W)-1:0]   spr_col,
    output logic [11:0]                background
);
    localparam int RW = $clog2(SPR_H);
    localparam int CW = $clog2(SPR_W);

    typedef enum logic [1:0] {D_RIGHT = 2'd0, D_LEFT = 2'd1, D_UP = 2'd2, D_DOWN = 2'd3} dir_t;
    typedef enum logic {S_IDLE = 1'b0, S_MOVING = 1'b1} state_t;

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    dir_t        pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  xs_q, ys_q;
    logic [11:0] bg_q, bg_d;
    logic        hit_q, hit_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    function automatic logic [11:0] dir_colour(input dir_t d);
        case (d)
            D_RIGHT: return 12'hFF0;
            D_LEFT:  return 12'h0FF;
            D_UP:    return 12'h00F;
            default: return 12'h0F0;
        endcase
    endfunction

    // Movement next-state. A button seen this cycle overrides the latched
    // request so that a capture coinciding with tick is evaluated at once.
    logic  btn_v, pend_v_eff, do_adv;
    dir_t  btn_dir, pend_eff, mv_dir;
    logic [10:0] x11, y11;

    always_comb begin
        btn_v      = right | left | up | down;
        btn_dir    = right ? D_RIGHT : left ? D_LEFT : up ? D_UP : D_DOWN;
        pend_v_eff = btn_v | pend_v_q;
        pend_eff   = btn_v ? btn_dir : pend_q;

        state_d  = state_q;
        dir_d    = dir_q;
        pend_d   = pend_eff;
        pend_v_d = pend_v_eff;
        bg_d     = bg_q;
        x_d      = x_q;
        y_d      = y_q;
        mv_dir   = dir_q;
        do_adv   = 1'b0;
        x11      = {1'b0, x_q};
        y11      = {1'b0, y_q};

        if (tick) begin
            if (pend_v_eff && !blocked[pend_eff]) begin
                dir_d    = pend_eff;
                pend_v_d = 1'b0;
                state_d  = S_MOVING;
                bg_d     = dir_colour(pend_eff);
                mv_dir   = pend_eff;
                do_adv   = 1'b1;
            end else if (state_q == S_MOVING && blocked[dir_q]) begin
                state_d = S_IDLE;
            end else if (state_q == S_MOVING) begin
                do_adv = 1'b1;
            end
        end

        // 11-bit arithmetic so overshoot past a bound is visible before wrap/clamp.
        if (do_adv) begin
            case (mv_dir)
                D_RIGHT:
                    if (x11 + 11'(STEP) > 11'(X_MAX)) begin
                        x_d = WRAP ? 10'(X_MIN) : 10'(X_MAX);
                        if (!WRAP) state_d = S_IDLE;
                    end else x_d = 10'(x11 + 11'(STEP));
                D_LEFT:
                    if (x11 < 11'(X_MIN + STEP)) begin
                        x_d = WRAP ? 10'(X_MAX) : 10'(X_MIN);
                        if (!WRAP) state_d = S_IDLE;
                    end else x_d = 10'(x11 - 11'(STEP));
                D_UP:
                    if (y11 < 11'(Y_MIN + STEP)) begin
                        y_d = WRAP ? 10'(Y_MAX) : 10'(Y_MIN);
                        if (!WRAP) state_d = S_IDLE;
                    end else y_d = 10'(y11 - 11'(STEP));
                default:
                    if (y11 + 11'(STEP) > 11'(Y_MAX)) begin
                        y_d = WRAP ? 10'(Y_MIN) : 10'(Y_MAX);
                        if (!WRAP) state_d = S_IDLE;
                    end else y_d = 10'(y11 + 11'(STEP));
            endcase
        end
    end

    // Pixel test against the frame-latched shadow position only.
    logic in_x, in_y;
    logic [CW-1:0] dx;

    always_comb begin
        in_x  = ({1'b0, hCount} >= {1'b0, xs_q}) &&
                ({1'b0, hCount} <= {1'b0, xs_q} + 11'(SPR_W - 1));
        in_y  = ({1'b0, vCount} >= {1'b0, ys_q}) &&
                ({1'b0, vCount} <= {1'b0, ys_q} + 11'(SPR_H - 1));
        hit_d = bright && in_x && in_y;
        dx    = CW'(hCount - xs_q);
        row_d = '0;
        col_d = '0;
        if (hit_d) begin
            row_d = RW'(vCount - ys_q);
            col_d = (MIRROR && dir_q == D_LEFT) ? CW'(SPR_W - 1) - dx : dx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            dir_q    <= D_RIGHT;
            pend_q   <= D_RIGHT;
            pend_v_q <= 1'b0;
            x_q      <= 10'(X_INIT);
            y_q      <= 10'(Y_INIT);
            xs_q     <= 10'(X_INIT);
            ys_q     <= 10'(Y_INIT);
            bg_q     <= 12'hFFF;
            hit_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bg_q     <= bg_d;
            hit_q    <= hit_d;
            row_q    <= row_d;
            col_q    <= col_d;
            if (hCount == 10'd0 && vCount == 10'd0) begin
                xs_q <= x_q;
                ys_q <= y_q;
            end
        end
    end

    assign xpos       = x_q;
    assign ypos       = y_q;
    assign dir        = dir_q;
    assign moving     = (state_q == S_MOVING);
    assign sprite_hit = hit_q;
    assign spr_row    = row_q;
    assign spr_col    = col_q;
    assign background = bg_q;

endmodule
